key_event_detector: RTL and testbench
=====================================

# key_event_detector

Input-side counterpart to the LED pattern state machine: conditions the raw active-low push-button bank (KEY) and turns it into clean per-key events for the control logic. Each key passes through a two-flop synchronizer and a four-state debounce FSM. The block emits a held `pressed` level, single-cycle press/release pulses and a single-cycle long-press pulse. One instance sits in a board top, between the KEY pins and any LED or timer controller.

## Interface
- WIDTH, 4, number of keys handled (independent per-key channels).
- DEBOUNCE_CYCLES, 500000, clocks a level must stay stable to be accepted (10 ms at 50 MHz); legal range ≥ 2.
- LONG_CYCLES, 50000000, clocks of accepted hold before the long-press pulse (1 s at 50 MHz); legal range > DEBOUNCE_CYCLES.

- clock  input  1  system clock (CLOCK_50 domain).
- reset  input  1  asynchronous, active-high reset.
- key_n  input  WIDTH  raw buttons, active-low (0 = pushed), asynchronous to clock.
- pressed  output  WIDTH  debounced level, 1 while the key is accepted as held.
- press_pulse  output  WIDTH  one-cycle pulse on accepted press.
- release_pulse  output  WIDTH  one-cycle pulse on accepted release.
- long_pulse  output  WIDTH  one-cycle pulse when an accepted hold reaches LONG_CYCLES.

## Operation
- Synchronizer: two flops per key, reset value 1 (released). The FSM sees only the second flop, `s`.
- Counters per key:
  - debounce counter `dc`, width $clog2(DEBOUNCE_CYCLES).
  - hold counter `hc`, width $clog2(LONG_CYCLES+1), saturating.
- FSM per key. States are IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT; reset state is IDLE.
  - IDLE: if `s`==0, go to PRESS_WAIT and set dc=0.
  - PRESS_WAIT:
    - `s`==1: back to IDLE (bounce rejected, no pulse).
    - `s`==0 and dc==DEBOUNCE_CYCLES-1: go to PRESSED, set pressed=1, press_pulse=1 for one cycle, hc=0.
    - otherwise dc++.
  - PRESSED:
    - hc++ each cycle until it saturates at LONG_CYCLES.
    - The cycle hc becomes LONG_CYCLES, long_pulse=1 for one cycle. This happens at most once per accepted press.
    - If `s`==1, go to RELEASE_WAIT and set dc=0; hc holds its value.
  - RELEASE_WAIT:
    - `s`==0: back to PRESSED (release glitch rejected). hc resumes from its held value, no pulse, pressed stays 1.
    - `s`==1 and dc==DEBOUNCE_CYCLES-1: go to IDLE, set pressed=0, release_pulse=1 for one cycle.
    - otherwise dc++.
- All outputs are registered. Keys are fully independent; simultaneous events on different keys produce simultaneous pulses.
- press_pulse, release_pulse and long_pulse are never asserted for more than one consecutive cycle per key.
- pressed is 1 exactly in PRESSED and RELEASE_WAIT.

## Timing
- Reset value:
  - all outputs 0.
  - all FSMs in IDLE, all counters 0.
  - synchronizer flops 1.
- Reset is asynchronous assert. A reset mid-debounce or mid-hold discards the event: no pulse, and pressed returns to 0 immediately.
- A key held low through reset deassertion is accepted as a new press after the full latency.
- Press latency: key_n falls and stays low; call the first clock edge that samples it low edge 1. pressed and press_pulse go high after edge DEBOUNCE_CYCLES+3.
- Release latency: the same, DEBOUNCE_CYCLES+3 edges after key_n returns high.
- Long-press: long_pulse is high in the cycle after edge LONG_CYCLES, counting from the edge that asserted press_pulse. Cycles spent in RELEASE_WAIT are not counted.
- Any bounce shorter than DEBOUNCE_CYCLES at the FSM input restarts acceptance. The glitch adds no events.

## Test plan
Bench parameters: WIDTH=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
- Reset behaviour: assert reset with key_n=4'b0000 → all outputs 0. Release reset → press_pulse=4'b1111 for one cycle, 7 edges after the first sampling edge; pressed=4'b1111 from then on.
- Clean press and release on key 0: low for 8 cycles, then high.
  - press_pulse[0] fires once at edge 7.
  - release_pulse[0] fires once 7 edges after the rising edge.
  - long_pulse[0] never fires.
- Bounce rejection: key 1 low 2 cycles, high 1, low 2, then high → no pulses, pressed[1]=0 throughout.
- Long press on key 2: low for 20 cycles.
  - press_pulse at edge 7.
  - long_pulse exactly once, 10 edges after press_pulse.
  - pressed[2]=1 until the release is accepted.
- Release glitch on key 3 while held: a 2-cycle high blip → pressed[3] stays 1, no release_pulse. long_pulse is delayed by the cycles spent in RELEASE_WAIT.
- Reset mid-hold: key 0 pressed, assert reset 3 cycles before long_pulse is due → outputs 0 immediately, and no long_pulse appears.

Source files
------------

// File: rtl/key_event_detector.sv
// Push-button conditioner: per-key two-flop synchronizer and debounce FSM that turns
// raw active-low keys into a held level plus press, release and long-press pulses.
//
// state        | meaning
// IDLE         | key released, waiting for a low level
// PRESS_WAIT   | low seen, counting stable-low cycles before accepting the press
// PRESSED      | press accepted, counting hold time towards the long-press pulse
// RELEASE_WAIT | high seen while held, counting stable-high cycles before accepting release
module key_event_detector #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] key_n,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] long_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HC_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HC_PRE  = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t           state [WIDTH];
    logic [DW-1:0]    dc    [WIDTH];
    logic [HW-1:0]    hc    [WIDTH];
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1         <= '1;
            s             <= '1;
            pressed       <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            long_pulse    <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= IDLE;
                dc[i]    <= '0;
                hc[i]    <= '0;
            end
        end else begin
            sync1         <= key_n;
            s             <= sync1;
            press_pulse   <= '0;
            release_pulse <= '0;
            long_pulse    <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                case (state[i])
                    IDLE: begin
                        if (!s[i]) begin
                            state[i] <= PRESS_WAIT;
                            dc[i]    <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (s[i]) begin
                            state[i] <= IDLE;
                        end else if (dc[i] == DC_LAST) begin
                            state[i]       <= PRESSED;
                            pressed[i]     <= 1'b1;
                            press_pulse[i] <= 1'b1;
                            hc[i]          <= '0;
                        end else begin
                            dc[i] <= dc[i] + DW'(1);
                        end
                    end
                    PRESSED: begin
                        // hold time freezes while a possible release is being qualified
                        if (s[i]) begin
                            state[i] <= RELEASE_WAIT;
                            dc[i]    <= '0;
                        end else if (hc[i] != HC_MAX) begin
                            hc[i] <= hc[i] + HW'(1);
                            if (hc[i] == HC_PRE) begin
                                long_pulse[i] <= 1'b1;
                            end
                        end
                    end
                    RELEASE_WAIT: begin
                        if (!s[i]) begin
                            state[i] <= PRESSED;
                        end else if (dc[i] == DC_LAST) begin
                            state[i]         <= IDLE;
                            pressed[i]       <= 1'b0;
                            release_pulse[i] <= 1'b1;
                        end else begin
                            dc[i] <= dc[i] + DW'(1);
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_event_detector.sv
// Directed bench for key_event_detector with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
// Loop index n counts clock edges; key_n set in iteration n is first sampled by edge n.
module tb_key_event_detector;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key_n = 4'b0000;
    logic [3:0] pressed, press_pulse, release_pulse, long_pulse;

    int checks = 0;
    int errors = 0;

    key_event_detector #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(10)
    ) dut (
        .clock(clock),
        .reset(reset),
        .key_n(key_n),
        .pressed(pressed),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int n, input logic [3:0] e_pr,
                             input logic [3:0] e_pp, input logic [3:0] e_rp,
                             input logic [3:0] e_lp);
        check($sformatf("%s pressed n=%0d", tag, n), pressed, e_pr);
        check($sformatf("%s press_pulse n=%0d", tag, n), press_pulse, e_pp);
        check($sformatf("%s release_pulse n=%0d", tag, n), release_pulse, e_rp);
        check($sformatf("%s long_pulse n=%0d", tag, n), long_pulse, e_lp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // reset held with every key pushed
        repeat (3) tick();
        check_all("rst", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            key_n = (n <= 10) ? 4'b0000 : 4'b1111;
            tick();
            check_all("rst_hold", n,
                      (n >= 7 && n <= 16) ? 4'b1111 : 4'b0000,
                      (n == 7)  ? 4'b1111 : 4'b0000,
                      (n == 17) ? 4'b1111 : 4'b0000,
                      4'b0000);
        end

        // clean press/release on key 0
        for (int n = 1; n <= 18; n++) begin
            key_n = (n <= 8) ? 4'b1110 : 4'b1111;
            tick();
            check_all("clean", n,
                      (n >= 7 && n <= 14) ? 4'b0001 : 4'b0000,
                      (n == 7)  ? 4'b0001 : 4'b0000,
                      (n == 15) ? 4'b0001 : 4'b0000,
                      4'b0000);
        end

        // bounce on key 1: low 2, high 1, low 2, high
        for (int n = 1; n <= 14; n++) begin
            key_n = (n == 1 || n == 2 || n == 4 || n == 5) ? 4'b1101 : 4'b1111;
            tick();
            check_all("bounce", n, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end

        // long press on key 2: low 20 cycles
        for (int n = 1; n <= 30; n++) begin
            key_n = (n <= 20) ? 4'b1011 : 4'b1111;
            tick();
            check_all("long", n,
                      (n >= 7 && n <= 26) ? 4'b0100 : 4'b0000,
                      (n == 7)  ? 4'b0100 : 4'b0000,
                      (n == 27) ? 4'b0100 : 4'b0000,
                      (n == 17) ? 4'b0100 : 4'b0000);
        end

        // key 3 held with a 2-cycle high blip; hold count pauses for 3 edges
        for (int n = 1; n <= 40; n++) begin
            key_n = (n <= 30 && n != 10 && n != 11) ? 4'b0111 : 4'b1111;
            tick();
            check_all("glitch", n,
                      (n >= 7 && n <= 36) ? 4'b1000 : 4'b0000,
                      (n == 7)  ? 4'b1000 : 4'b0000,
                      (n == 37) ? 4'b1000 : 4'b0000,
                      (n == 20) ? 4'b1000 : 4'b0000);
        end

        // reset mid-hold on key 0, long pulse would be due at n=17
        for (int n = 1; n <= 13; n++) begin
            key_n = 4'b1110;
            tick();
            check_all("midhold", n,
                      (n >= 7) ? 4'b0001 : 4'b0000,
                      (n == 7) ? 4'b0001 : 4'b0000,
                      4'b0000, 4'b0000);
        end
        reset = 1'b1;
        #1;
        check_all("midhold_async", 14, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        key_n = 4'b1111;
        tick();
        tick();
        reset = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            tick();
            check_all("after_rst", n, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
